seq_scheduler: RTL and testbench

//  Shares one sequencer (seq/start/running/done interface) between NUM_REQ requesters.

---
 rtl/seq_scheduler_pkg.sv | 10 +
 rtl/seq_scheduler_rr_arbiter.sv | 28 ++
 rtl/seq_scheduler.sv | 74 +++++++
 tb/tb_seq_scheduler.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/seq_scheduler_pkg.sv
// seq_scheduler_pkg: shared state encoding and width helper for the sequencer scheduler
package seq_scheduler_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;
  function automatic int clog2w(input int v);
    int w;
    w = 1;
    while ((1 << w) < v) w++;
    return w;
  endfunction
endpackage

// File: rtl/seq_scheduler_rr_arbiter.sv
// seq_rr_arbiter: combinational round-robin pick searching upward from ptr+1 with wrap
module seq_rr_arbiter
  import seq_scheduler_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (int'(ptr) + k) % N;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end
endmodule

// File: rtl/seq_scheduler.sv
// seq_scheduler: round-robin sharing of one sequencer between NUM_REQ requesters, with watchdog
module seq_scheduler
  import seq_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SEQ_W   = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*SEQ_W-1:0] req_seq,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       req_done,
  output logic                     req_timeout,
  output logic [SEQ_W-1:0]         seq,
  output logic                     start,
  input  logic                     running,
  input  logic                     done,
  output logic                     busy
);
  localparam int IW = clog2w(NUM_REQ);
  localparam int CW = clog2w(TIMEOUT + 1);
  // last WAIT cycle index (counter starts at 0), so the run spans exactly TIMEOUT WAIT cycles
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  state_t state, nxt;
  logic [IW-1:0] ptr, owner, win_idx;
  logic [NUM_REQ-1:0] win_gnt, own_oh;
  logic [SEQ_W-1:0] seq_q;
  logic [CW-1:0] cnt;
  logic abort, win_valid, expire, unused;
  assign unused = running;
  seq_rr_arbiter #(.N(NUM_REQ), .IW(IW)) arb (
    .req(req), .ptr(ptr), .gnt(win_gnt), .idx(win_idx), .valid(win_valid)
  );
  assign expire = (TIMEOUT != 0) && (cnt == TLIM);
  assign own_oh = NUM_REQ'(1) << owner;
  always_comb begin
    nxt = state == IDLE  ? (win_valid ? START : IDLE) :
          state == START ? WAIT :
          state == WAIT  ? ((done || expire) ? DONE : WAIT) : IDLE;
    busy        = state != IDLE;
    start       = state == START;
    grant       = busy ? own_oh : '0;
    seq         = busy ? seq_q : '0;
    req_done    = state == DONE ? own_oh : '0;
    req_timeout = state == DONE && abort;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= IW'(NUM_REQ - 1);
      owner <= '0;
      seq_q <= '0;
      cnt   <= '0;
      abort <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && win_valid) begin
        owner <= win_idx;
        seq_q <= req_seq[int'(win_idx)*SEQ_W +: SEQ_W];
      end
      if (state == START) begin
        cnt   <= '0;
        abort <= 1'b0;
      end
      if (state == WAIT) begin
        cnt   <= (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
        abort <= expire && !done;
      end
      if (state == DONE) ptr <= owner;
    end
  end
endmodule

// File: tb/tb_seq_scheduler.sv
// tb_seq_scheduler: table-driven and randomized transaction checks of seq_scheduler
module tb_seq_scheduler;
  logic clk = 0, reset = 1, running = 0, done = 0;
  logic [3:0] req = 0, req_seq = 0, grant, req_done;
  logic [0:0] seq;
  logic req_timeout, start, busy;
  int checks = 0, failures = 0, ptr_m = 3;

  seq_scheduler #(.NUM_REQ(4), .SEQ_W(1), .TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .req(req), .req_seq(req_seq), .grant(grant),
    .req_done(req_done), .req_timeout(req_timeout), .seq(seq), .start(start),
    .running(running), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] r, s;
    int k;
    logic st, wd;
    logic [3:0] eg;
    logic es, et;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rr_pick(input int p, input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(p + k) % 4]) return 4'b1 << ((p + k) % 4);
    return 4'b0;
  endfunction

  function automatic int oh_idx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_seq"}, seq, 0);
    chk({tag, "_done"}, req_done, 0);
    chk({tag, "_tmo"}, req_timeout, 0);
  endtask

  // one full run: called in an IDLE cycle; returns in the IDLE cycle after req_done
  task automatic run(input vec_t v);
    int n;
    req = v.r;
    req_seq = v.s;
    tick();
    chk("start", start, 1);
    chk("start_grant", grant, v.eg);
    chk("start_seq", seq, v.es);
    chk("start_busy", busy, 1);
    done = v.st;
    running = 1;
    tick();
    done = 0;
    if (v.wd) begin
      req = (req & ~v.eg) | 4'b0100;
      req_seq = ~req_seq;
    end
    n = v.k > 20 ? 20 : v.k;
    for (int i = 1; i <= n; i++) begin
      chk("wait_start", start, 0);
      chk("wait_grant", grant, v.eg);
      chk("wait_seq", seq, v.es);
      chk("wait_done", req_done, 0);
      done = (i == v.k);
      tick();
      done = 0;
    end
    running = 0;
    chk("req_done", req_done, v.eg);
    chk("req_timeout", req_timeout, v.et);
    chk("done_grant", grant, v.eg);
    req = req & ~v.eg;
    ptr_m = oh_idx(v.eg);
    tick();
    chk("post_busy", busy, 0);
    chk("post_done", req_done, 0);
    chk("post_grant", grant, 0);
  endtask

  vec_t tbl[10];
  vec_t v;

  initial begin
    tbl[0] = '{4'b0001, 4'b0001, 15, 0, 0, 4'b0001, 1, 0};
    tbl[1] = '{4'b1111, 4'b1010, 3, 0, 0, 4'b0010, 1, 0};
    tbl[2] = '{4'b1111, 4'b1010, 1, 0, 0, 4'b0100, 0, 0};
    tbl[3] = '{4'b1111, 4'b0101, 5, 1, 0, 4'b1000, 0, 0};
    tbl[4] = '{4'b1111, 4'b0101, 2, 0, 0, 4'b0001, 1, 0};
    tbl[5] = '{4'b0101, 4'b0100, 24, 0, 0, 4'b0100, 1, 1};
    tbl[6] = '{4'b0101, 4'b0001, 20, 0, 0, 4'b0001, 1, 0};
    tbl[7] = '{4'b1001, 4'b1000, 7, 0, 0, 4'b1000, 1, 0};
    tbl[8] = '{4'b0110, 4'b0110, 4, 0, 1, 4'b0010, 1, 0};
    tbl[9] = '{4'b0100, 4'b0000, 2, 0, 0, 4'b0100, 0, 0};
    tick();
    tick();
    check_idle("reset");
    reset = 0;
    tick();
    check_idle("idle");
    for (int i = 0; i < 10; i++) run(tbl[i]);
    // reset in the middle of a WAIT phase
    req = 4'b0010;
    req_seq = 4'b0010;
    tick();
    chk("rst_pre_grant", grant, rr_pick(ptr_m, 4'b0010));
    tick();
    tick();
    tick();
    reset = 1;
    req = 4'b1111;
    tick();
    check_idle("rst_mid");
    reset = 0;
    ptr_m = 3;
    run('{4'b1111, 4'b0001, 3, 0, 0, 4'b0001, 1, 0});
    // randomized runs against the rotation model
    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      req = 0;
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("gap_busy", busy, 0);
      end
      v.r = 4'($urandom_range(1, 15));
      v.s = 4'($urandom);
      v.k = $urandom_range(1, 24);
      v.st = 1'($urandom);
      v.wd = 0;
      v.eg = rr_pick(ptr_m, v.r);
      v.es = |(v.s & v.eg);
      v.et = v.k > 20;
      run(v);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
